// File: rtl/counter_8bit_capture_fifo_pkg.sv
// Shared definitions for the counter blocks: default sizes and the
// helper that gives the width of a 0..DEPTH occupancy count.
package counter_8bit_capture_fifo_pkg;

  localparam int CNT_WIDTH  = 8;
  localparam int FIFO_DEPTH = 4;

  // Occupancy runs 0..depth inclusive, so it needs one bit above the pointer.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/counter_8bit_capture_fifo_capture_fifo.sv
// Capture FIFO: storage, pointers and occupancy with a registered head so
// out_data/out_valid/level never see a combinational path from the inputs.
module capture_fifo
  import counter_8bit_capture_fifo_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          wr_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_nxt;
  logic             valid_q;
  logic             is_full;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] head_nxt;

  always_comb begin
    is_full    = (level_q == LVL_FULL);
    pop        = valid_q & rd_en;
    // A full FIFO still accepts a write when the head leaves at the same edge.
    push       = wr_en & (~is_full | pop);
    wr_drop    = wr_en & is_full & ~pop;
    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt  = level_q;
    if (push && !pop) begin
      level_nxt = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt = level_q - LVL_W'(1);
    end
    // The new head is the incoming word only when it lands in an otherwise empty FIFO.
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = wr_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      level_q <= level_nxt;
      valid_q <= (level_nxt != '0);
    end
  end

  // Storage and head register carry data only; they hold across reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
    if (level_nxt != '0) begin
      data_q <= head_nxt;
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign level    = level_q;

endmodule

// File: rtl/counter_8bit_capture_fifo.sv
// Captures the upstream counter value on each rising edge of event_in into
// a small FIFO; a capture refused by a full FIFO raises a sticky overflow.
module counter_8bit_capture_fifo
  import counter_8bit_capture_fifo_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic [WIDTH-1:0]              count_in,
  input  logic                          event_in,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  logic event_q;
  logic capture;
  logic wr_drop;

  // event_q resets high so a level held through reset release is not an edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      event_q <= 1'b1;
    end else begin
      event_q <= event_in;
    end
  end

  assign capture = event_in & ~event_q;

  capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetb   (resetb),
    .wr_en    (capture),
    .wr_data  (count_in),
    .rd_en    (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .level    (level),
    .wr_drop  (wr_drop)
  );

  // A drop at the same edge as a clear request keeps the flag set.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
